// File: rtl/fsm_seq_checker_if.sv
// Bus bundle between the state-sequencer side and the sequence checker.
// master drives tick/estados and observes status; slave is the checker.
interface fsm_seq_checker_if #(
    parameter int ERR_W = 8,
    parameter int CYC_W = 16
);
    logic             tick;
    logic [1:0]       estados;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [CYC_W-1:0] cycles;
    logic             dir;
    logic [1:0]       fsm_state;

    modport master (
        output tick, estados,
        input  locked, err_pulse, err_count, cycles, dir, fsm_state
    );

    modport slave (
        input  tick, estados,
        output locked, err_pulse, err_count, cycles, dir, fsm_state
    );
endinterface

// File: rtl/fsm_seq_checker.sv
// Lock monitor for the 2-bit cyclic sequencer state bus, sampled on tick.
// Optional REVERSE_DET_EN also accepts a consistently descending sequence.
//
// state | meaning
// HUNT  | no reference yet; next tick captures prev
// ACQ   | counting consecutive good steps toward LOCK_N
// LOCK  | locked; bad steps are errors, wraps are counted
module fsm_seq_checker #(
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8,
    parameter int CYC_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    fsm_seq_checker_if.slave   bus
);
    localparam int RUN_W = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       prev, prev_nxt;
    logic [RUN_W-1:0] run, run_nxt, run_inc;
    logic             dir_q, dir_nxt;
    logic             locked_q, locked_nxt;
    logic             pulse_q, pulse_nxt;
    logic [ERR_W-1:0] err_q, err_nxt;
    logic [CYC_W-1:0] cyc_q, cyc_nxt;

    logic step_up;
    logic step_any;
    logic step_dir;
    logic wrap;

    assign step_up = (bus.estados == 2'(prev + 2'd1));
    assign run_inc = run + 1'b1;

`ifdef REVERSE_DET_EN
    logic step_dn;
    assign step_dn  = (bus.estados == 2'(prev - 2'd1));
    assign step_any = step_up | step_dn;
    assign step_dir = step_dn;
    assign wrap     = ((prev == 2'd3) && (bus.estados == 2'd0)) ||
                      ((prev == 2'd0) && (bus.estados == 2'd3));
`else
    assign step_any = step_up;
    assign step_dir = 1'b0;
    assign wrap     = (prev == 2'd3) && (bus.estados == 2'd0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            prev     <= 2'd0;
            run      <= '0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            err_q    <= '0;
            cyc_q    <= '0;
        end else begin
            state    <= state_nxt;
            prev     <= prev_nxt;
            run      <= run_nxt;
            dir_q    <= dir_nxt;
            locked_q <= locked_nxt;
            pulse_q  <= pulse_nxt;
            err_q    <= err_nxt;
            cyc_q    <= cyc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        run_nxt   = run;
        dir_nxt   = dir_q;
        pulse_nxt = 1'b0;
        err_nxt   = err_q;
        cyc_nxt   = cyc_q;

        if (bus.tick) begin
            prev_nxt = bus.estados;
            case (state)
                HUNT: begin
                    run_nxt   = '0;
                    state_nxt = ACQ;
                end
                ACQ: begin
                    // A fresh run (run==0) accepts either direction and latches it.
                    if (step_any && ((run == '0) || (step_dir == dir_q))) begin
                        run_nxt = run_inc;
                        dir_nxt = step_dir;
                        if (run_inc == RUN_W'(LOCK_N)) begin
                            state_nxt = LOCK;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                LOCK: begin
                    if (step_any && (step_dir == dir_q)) begin
                        if (wrap && !(&cyc_q)) begin
                            cyc_nxt = cyc_q + 1'b1;
                        end
                    end else begin
                        pulse_nxt = 1'b1;
                        if (!(&err_q)) begin
                            err_nxt = err_q + 1'b1;
                        end
                        run_nxt   = '0;
                        state_nxt = ACQ;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end

        locked_nxt = (state_nxt == LOCK);
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;
    assign bus.err_count = err_q;
    assign bus.cycles    = cyc_q;
    assign bus.dir       = dir_q;
    assign bus.fsm_state = state;
endmodule
